// File: rtl/ysyx_23060236_axi4_sram.sv
// AXI4 slave SRAM model: independent read/write channels, INCR/WRAP/FIXED
// bursts, configurable read latency, SLVERR/DECERR responses.
module ysyx_23060236_axi4_sram #(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned RD_LATENCY  = 2
) (
  input  logic        clock,
  input  logic        reset,
  // write address
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awid,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  // write data
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  // write response
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  output logic [3:0]  bid,
  // read address
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  input  logic [3:0]  arid,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  // read data
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic [3:0]  rid
);

  localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  LAT_INIT = 4'(RD_LATENCY);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rstate_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;

  logic [31:0] mem_q [DEPTH_WORDS];

  function automatic logic in_range(input logic [31:0] a);
    return (a >= ADDR_BASE) && ({1'b0, a - ADDR_BASE} < SPAN);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
    return IDX_W'((a - ADDR_BASE) >> 2);
  endfunction

  function automatic logic cfg_err(input logic [7:0] len, input logic [2:0] size,
                                   input logic [1:0] burst);
    logic bad_wrap;
    bad_wrap = (burst == 2'b10) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15});
    return (size > 3'd2) || (burst == 2'b11) || bad_wrap;
  endfunction

  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] step;
    logic [31:0] mask;
    logic [31:0] res;
    step = 32'd1 << size;
    mask = ((32'(len) + 32'd1) * step) - 32'd1;
    case (burst)
      2'b00:   res = a;
      2'b10:   res = (a & ~mask) | ((a + step) & mask);
      default: res = a + step;
    endcase
    return res;
  endfunction

  // ---------------- read channel ----------------
  rstate_e     r_state_q;
  logic [31:0] r_addr_q;
  logic [7:0]  r_len_q, r_beat_q;
  logic [2:0]  r_size_q;
  logic [1:0]  r_burst_q;
  logic        r_err_q;
  logic [3:0]  r_lat_q;
  logic        arready_q, rvalid_q, rlast_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;
  logic [3:0]  rid_q;

  logic [31:0]      r_ld_addr_d;
  logic [7:0]       r_ld_beat_d, r_ld_len_d;
  logic             r_ld_err_d, r_ld_in;
  logic [IDX_W-1:0] r_ld_idx;
  logic [31:0]      r_ld_data;
  logic [1:0]       r_ld_resp;
  logic             r_ld_last;

  // Contents of the beat that would be loaded this edge (first beat or next beat)
  always_comb begin
    r_ld_addr_d = r_addr_q;
    r_ld_beat_d = '0;
    r_ld_len_d  = r_len_q;
    r_ld_err_d  = r_err_q;
    case (r_state_q)
      R_IDLE: begin
        r_ld_addr_d = araddr;
        r_ld_len_d  = arlen;
        r_ld_err_d  = cfg_err(arlen, arsize, arburst);
      end
      R_DATA: begin
        r_ld_addr_d = next_addr(r_addr_q, r_len_q, r_size_q, r_burst_q);
        r_ld_beat_d = r_beat_q + 8'd1;
      end
      default: ;
    endcase
    r_ld_in   = in_range(r_ld_addr_d);
    r_ld_idx  = word_idx(r_ld_addr_d);
    r_ld_data = r_ld_in ? mem_q[r_ld_idx] : '0;
    r_ld_resp = r_ld_err_d ? 2'b10 : (r_ld_in ? 2'b00 : 2'b11);
    r_ld_last = (r_ld_beat_d == r_ld_len_d);
  end

  // Read FSM with registered R-channel outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state_q <= R_IDLE;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_beat_q  <= '0;
      r_size_q  <= '0;
      r_burst_q <= '0;
      r_err_q   <= 1'b0;
      r_lat_q   <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      rid_q     <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (arvalid && arready_q) begin
            arready_q <= 1'b0;
            r_addr_q  <= araddr;
            r_len_q   <= arlen;
            r_size_q  <= arsize;
            r_burst_q <= arburst;
            r_err_q   <= r_ld_err_d;
            r_beat_q  <= '0;
            rid_q     <= arid;
            r_lat_q   <= LAT_INIT;
            if (RD_LATENCY == 0) begin
              rvalid_q  <= 1'b1;
              rdata_q   <= r_ld_data;
              rresp_q   <= r_ld_resp;
              rlast_q   <= r_ld_last;
              r_state_q <= R_DATA;
            end else begin
              r_state_q <= R_WAIT;
            end
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_WAIT: begin
          // Loading at count 1 gives exactly RD_LATENCY idle cycles.
          if (r_lat_q <= 4'd1) begin
            rvalid_q  <= 1'b1;
            rdata_q   <= r_ld_data;
            rresp_q   <= r_ld_resp;
            rlast_q   <= r_ld_last;
            r_state_q <= R_DATA;
          end else begin
            r_lat_q <= r_lat_q - 4'd1;
          end
        end
        R_DATA: begin
          if (rready) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              arready_q <= 1'b1;
              r_state_q <= R_IDLE;
            end else begin
              r_addr_q <= r_ld_addr_d;
              r_beat_q <= r_ld_beat_d;
              rdata_q  <= r_ld_data;
              rresp_q  <= r_ld_resp;
              rlast_q  <= r_ld_last;
            end
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  // ---------------- write channel ----------------
  wstate_e     w_state_q;
  logic [31:0] w_addr_q;
  logic [7:0]  w_len_q, w_beat_q;
  logic [2:0]  w_size_q;
  logic [1:0]  w_burst_q;
  logic        w_err_q, w_dec_q;
  logic        awready_q, wready_q, bvalid_q;
  logic [1:0]  bresp_q;
  logic [3:0]  bid_q;

  logic             w_fire, w_in, w_mismatch;
  logic [IDX_W-1:0] w_idx;

  assign w_fire     = wvalid && wready_q;
  assign w_in       = in_range(w_addr_q);
  assign w_idx      = word_idx(w_addr_q);
  assign w_mismatch = wlast != (w_beat_q == w_len_q);

  // Byte-lane writes into the array; contents survive reset
  always_ff @(posedge clock) begin
    if (w_fire && w_in) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (wstrb[i]) mem_q[w_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Write FSM with registered AW/W/B handshake outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      w_state_q <= W_IDLE;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_beat_q  <= '0;
      w_size_q  <= '0;
      w_burst_q <= '0;
      w_err_q   <= 1'b0;
      w_dec_q   <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      bid_q     <= '0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (awvalid && awready_q) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            w_addr_q  <= awaddr;
            w_len_q   <= awlen;
            w_size_q  <= awsize;
            w_burst_q <= awburst;
            w_err_q   <= cfg_err(awlen, awsize, awburst);
            w_dec_q   <= 1'b0;
            w_beat_q  <= '0;
            bid_q     <= awid;
            w_state_q <= W_DATA;
          end else begin
            awready_q <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            w_addr_q <= next_addr(w_addr_q, w_len_q, w_size_q, w_burst_q);
            w_beat_q <= w_beat_q + 8'd1;
            if (!w_in) w_dec_q <= 1'b1;
            if (w_mismatch) w_err_q <= 1'b1;
            if (wlast) begin
              // Flags updated this beat are folded in directly; SLVERR wins over DECERR.
              wready_q  <= 1'b0;
              bvalid_q  <= 1'b1;
              bresp_q   <= (w_err_q || w_mismatch) ? 2'b10 :
                           ((w_dec_q || !w_in) ? 2'b11 : 2'b00);
              w_state_q <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            w_state_q <= W_IDLE;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign rlast   = rlast_q;
  assign rid     = rid_q;
  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;
  assign bid     = bid_q;

endmodule

// File: tb/tb_ysyx_23060236_axi4_sram.sv
// Scoreboard bench for ysyx_23060236_axi4_sram.
module tb_ysyx_23060236_axi4_sram;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [31:0] awaddr, wdata;
  logic [3:0]  awid, wstrb, bid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst, bresp;
  logic        arvalid, arready, rvalid, rready, rlast;
  logic [31:0] araddr, rdata;
  logic [3:0]  arid, rid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, rresp;

  always #5 clock = ~clock;

  ysyx_23060236_axi4_sram #(
    .ADDR_BASE(32'h8000_0000),
    .DEPTH_WORDS(4096),
    .RD_LATENCY(2)
  ) dut (
    .clock(clock), .reset(reset),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
    .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rid(rid)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } rbeat_t;

  typedef struct packed {
    logic [1:0] resp;
    logic [3:0] id;
  } bexp_t;

  rbeat_t      rq[$];
  bexp_t       bq[$];
  int          r_pops = 0;
  logic [31:0] model [4096];
  logic [31:0] wbuf [16];
  logic [3:0]  sbuf [16];
  logic        rready_tgl = 1'b0;

  function automatic logic m_in(input logic [31:0] a);
    return (a >= BASE) && ((a - BASE) < 32'h0000_4000);
  endfunction

  function automatic int unsigned m_idx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  function automatic logic m_err(input logic [7:0] len, input logic [2:0] size,
                                 input logic [1:0] burst);
    logic bad;
    bad = (size > 3'd2) || (burst == 2'b11);
    if (burst == 2'b10 && len != 8'd1 && len != 8'd3 && len != 8'd7 && len != 8'd15) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [31:0] m_next(input logic [31:0] a, input logic [7:0] len,
                                         input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] step, bnd, lo;
    step = 32'd1 << size;
    if (burst == 2'b00) return a;
    if (burst == 2'b10) begin
      bnd = (32'(len) + 32'd1) * step;
      lo  = a - (a % bnd);
      return lo + ((a - lo + step) % bnd);
    end
    return a + step;
  endfunction

  // Scoreboard monitor: compare R/B fields against the queue head every valid cycle
  always @(negedge clock) begin
    if (rvalid === 1'b1) begin
      if (rq.size() == 0) begin
        check("r_unexpected", 64'd1, 64'd0);
      end else begin
        check("rdata", 64'(rdata), 64'(rq[0].data));
        check("rctl", 64'({rid, rlast, rresp}), 64'({rq[0].id, rq[0].last, rq[0].resp}));
        if (rready) begin
          void'(rq.pop_front());
          r_pops++;
        end
      end
    end
    if (bvalid === 1'b1) begin
      if (bq.size() == 0) begin
        check("b_unexpected", 64'd1, 64'd0);
      end else begin
        check("bresp_bid", 64'({bresp, bid}), 64'({bq[0].resp, bq[0].id}));
        if (bready) void'(bq.pop_front());
      end
    end
  end

  // rready: held high, or toggling every cycle for backpressure
  initial begin
    rready = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      rready = rready_tgl ? ~rready : 1'b1;
    end
  end

  task automatic send_ar(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] a;
    logic        e, ok;
    rbeat_t      b;
    a = addr;
    e = m_err(len, size, burst);
    for (int i = 0; i <= int'(len); i++) begin
      b.data = m_in(a) ? model[m_idx(a)] : 32'h0;
      b.resp = e ? 2'b10 : (m_in(a) ? 2'b00 : 2'b11);
      b.last = (i == int'(len));
      b.id   = id;
      rq.push_back(b);
      a = m_next(a, len, size, burst);
    end
    @(posedge clock);
    #1;
    arvalid = 1'b1; araddr = addr; arid = id; arlen = len; arsize = size; arburst = burst;
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clock);
      if (arready) ok = 1'b1;
    end
    check("ar_accept", 64'(ok), 64'd1);
    @(posedge clock);
    #1;
    arvalid = 1'b0;
  endtask

  task automatic wait_r_drain();
    for (int k = 0; k < 300 && rq.size() != 0; k++) @(negedge clock);
    check("r_drain", 64'(rq.size()), 64'd0);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int nbeats);
    logic [31:0] a, m;
    logic        e, dec, ok;
    bexp_t       b;
    e   = m_err(len, size, burst) || (nbeats != int'(len) + 1);
    dec = 1'b0;
    a   = addr;
    for (int i = 0; i < nbeats; i++) begin
      if (m_in(a)) begin
        m = model[m_idx(a)];
        for (int j = 0; j < 4; j++) if (sbuf[i][j]) m[8*j +: 8] = wbuf[i][8*j +: 8];
        model[m_idx(a)] = m;
      end else begin
        dec = 1'b1;
      end
      a = m_next(a, len, size, burst);
    end
    b.resp = e ? 2'b10 : (dec ? 2'b11 : 2'b00);
    b.id   = id;
    bq.push_back(b);
    @(posedge clock);
    #1;
    awvalid = 1'b1; awaddr = addr; awid = id; awlen = len; awsize = size; awburst = burst;
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clock);
      if (awready) ok = 1'b1;
    end
    check("aw_accept", 64'(ok), 64'd1);
    @(posedge clock);
    #1;
    awvalid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      wvalid = 1'b1; wdata = wbuf[i]; wstrb = sbuf[i]; wlast = (i == nbeats - 1);
      ok = 1'b0;
      for (int k = 0; k < 100 && !ok; k++) begin
        @(negedge clock);
        if (wready) ok = 1'b1;
      end
      check("w_accept", 64'(ok), 64'd1);
      @(posedge clock);
      #1;
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    for (int k = 0; k < 100 && bq.size() != 0; k++) @(negedge clock);
    check("b_done", 64'(bq.size()), 64'd0);
  endtask

  initial begin
    int n;
    int base_pops;
    awvalid = 1'b0; awaddr = '0; awid = '0; awlen = '0; awsize = '0; awburst = '0;
    wvalid = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0; bready = 1'b1;
    arvalid = 1'b0; araddr = '0; arid = '0; arlen = '0; arsize = '0; arburst = '0;

    #1 reset = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_hs", 64'({arready, awready, wready, rvalid, bvalid}), 64'd0);
    check("rst_rfields", 64'({rdata, rresp, rlast, rid}), 64'd0);
    check("rst_bfields", 64'({bresp, bid}), 64'd0);
    reset = 1'b0;
    @(negedge clock);
    check("ready_after_rst", 64'({arready, awready}), 64'b11);

    // single write then read, with first-beat latency
    wbuf[0] = 32'hDEAD_BEEF; sbuf[0] = 4'b1111;
    do_write(32'h8000_0010, 4'h3, 8'd0, 3'd2, 2'b01, 1);
    send_ar(32'h8000_0010, 4'h5, 8'd0, 3'd2, 2'b01);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      n++;
      if (rvalid) break;
    end
    check("rd_latency", 64'(n), 64'd3);
    wait_r_drain();

    // byte strobe over an all-ones word
    wbuf[0] = 32'hFFFF_FFFF; sbuf[0] = 4'b1111;
    do_write(32'h8000_0020, 4'h1, 8'd0, 3'd2, 2'b01, 1);
    wbuf[0] = 32'h1122_3344; sbuf[0] = 4'b0010;
    do_write(32'h8000_0020, 4'h1, 8'd0, 3'd2, 2'b01, 1);
    send_ar(32'h8000_0020, 4'h2, 8'd0, 3'd2, 2'b01);
    wait_r_drain();

    // preload words with their own address, then WRAP read under backpressure
    for (int i = 0; i < 16; i++) begin
      wbuf[i] = BASE + 32'(4 * i);
      sbuf[i] = 4'b1111;
    end
    do_write(BASE, 4'h4, 8'd15, 3'd2, 2'b01, 16);
    rready_tgl = 1'b1;
    send_ar(32'h8000_0008, 4'h6, 8'd3, 3'd2, 2'b10);
    wait_r_drain();
    rready_tgl = 1'b0;

    // out of range first beat, in range second
    send_ar(32'h7FFF_FFFC, 4'h8, 8'd1, 3'd2, 2'b01);
    wait_r_drain();

    // write errors: early wlast, oversize, out-of-range
    wbuf[0] = 32'h0BAD_0001; sbuf[0] = 4'b1111;
    do_write(32'h8000_0200, 4'hA, 8'd1, 3'd2, 2'b01, 1);
    check("w_stopped", 64'(wready), 64'd0);
    do_write(32'h8000_0204, 4'hB, 8'd0, 3'd3, 2'b01, 1);
    do_write(32'h9000_0000, 4'hC, 8'd0, 3'd2, 2'b01, 1);

    // overlapped 16-beat read and 4-beat write
    for (int i = 0; i < 4; i++) begin
      wbuf[i] = $urandom;
      sbuf[i] = 4'b1111;
    end
    fork
      begin
        send_ar(BASE, 4'h7, 8'd15, 3'd2, 2'b01);
        wait_r_drain();
      end
      do_write(32'h8000_0100, 4'h9, 8'd3, 3'd2, 2'b01, 4);
    join
    send_ar(32'h8000_0100, 4'h1, 8'd3, 3'd2, 2'b01);
    wait_r_drain();

    // reset in the middle of a 16-beat read
    base_pops = r_pops;
    send_ar(BASE, 4'hD, 8'd15, 3'd2, 2'b01);
    for (int k = 0; k < 100 && r_pops < base_pops + 5; k++) begin
      @(negedge clock);
      #1;
    end
    check("rd_progress", 64'(r_pops - base_pops), 64'd5);
    @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    check("rvalid_on_rst", 64'(rvalid), 64'd0);
    rq.delete();
    repeat (2) @(negedge clock);
    check("rst2_hs", 64'({arready, awready, wready, rvalid, bvalid}), 64'd0);
    check("rst2_rfields", 64'({rdata, rresp, rlast, rid}), 64'd0);
    reset = 1'b0;
    @(negedge clock);
    check("arready_after_rst2", 64'(arready), 64'd1);
    repeat (5) @(negedge clock);
    send_ar(32'h8000_0100, 4'h2, 8'd3, 3'd2, 2'b01);
    wait_r_drain();

    repeat (3) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ysyx_23060236_axi4_sram.md
# ysyx_23060236_axi4_sram

AXI4 slave memory that sits directly downstream of the core's `io_master` port and serves instruction and data traffic in simulation and FPGA bring-up. It handles single-beat LSU accesses and IFU INCR/WRAP bursts. Read and write channels are independent, with a configurable read latency. Out-of-range accesses get AXI error responses instead of aliasing.

## Interface
- `ADDR_BASE`, default 32'h8000_0000: byte address of word 0.
- `DEPTH_WORDS`, default 4096: number of 32-bit words; must be a power of two.
- `RD_LATENCY`, default 2: idle cycles between the AR handshake and the first R beat (0–15).

- `clock` input 1: the single clock.
- `reset` input 1: asynchronous, active-high.
- `awvalid`/`awready` input/output 1: write address handshake.
- `awaddr` input 32, `awid` input 4, `awlen` input 8, `awsize` input 3, `awburst` input 2: write address fields.
- `wvalid`/`wready` input/output 1: write data handshake.
- `wdata` input 32, `wstrb` input 4, `wlast` input 1: write data fields.
- `bvalid`/`bready` output/input 1: write response handshake.
- `bresp` output 2, `bid` output 4: write response fields.
- `arvalid`/`arready` input/output 1: read address handshake.
- `araddr` input 32, `arid` input 4, `arlen` input 8, `arsize` input 3, `arburst` input 2: read address fields.
- `rvalid`/`rready` output/input 1: read data handshake.
- `rdata` output 32, `rresp` output 2, `rlast` output 1, `rid` output 4: read data fields.

## Operation
- **Reset values.** All ready and valid outputs are 0. `rdata`, `rresp`, `rlast`, `rid`, `bresp` and `bid` are 0. Both FSMs return to IDLE. Memory contents are not cleared.
- **Mid-burst reset.** Asserting reset during a burst aborts it. No further beats or responses are issued for that burst.

**Read FSM: R_IDLE → R_WAIT → R_DATA**
- R_IDLE: `arready`=1. On the AR handshake, latch address, id, len, size and burst, clear the beat counter, and load the latency counter with `RD_LATENCY`.
- R_WAIT: count down the latency counter. At 0, load the first beat and go to R_DATA. With `RD_LATENCY`=0, go straight from R_IDLE to R_DATA.
- R_DATA: `rvalid`=1.
  - `rdata` is the full 32-bit word at `addr[31:2]`. Lanes are not shifted for narrow sizes.
  - `rid` = latched id. `rlast` = (beat == len).
  - On the R handshake with `rlast`, go to R_IDLE. Otherwise advance the address and load the next beat in the same edge.
  - `rvalid` and all R fields stay stable until `rready`.

**Write FSM: W_IDLE → W_DATA → W_RESP**
- W_IDLE: `awready`=1. On the AW handshake, latch the AW fields and clear the error flag.
- W_DATA: `wready`=1.
  - Each W handshake writes the bytes of the current word enabled by `wstrb` and advances the address.
  - If `wlast` does not equal (beat == len), set the error flag.
  - Data beats keep being accepted until a beat with `wlast`=1, then go to W_RESP.
- W_RESP: `bvalid`=1, `bid` = latched id. `bresp` = 2'b10 if the error flag is set, else 2'b00. Return to W_IDLE on `bready`.

**Address and bursts (both channels)**
- Step = 1 << size. `size` > 2 sets the error flag (read: SLVERR on every beat).
- FIXED (2'b00): the address does not change.
- INCR (2'b01): address += step, 32-bit wrap-around.
- WRAP (2'b10):
  - Boundary = (len+1) × step. Address = (addr & ~(boundary−1)) | ((addr+step) & (boundary−1)).
  - `len` not in {1,3,7,15} → SLVERR on every beat or on B.
- Burst type 2'b11 → SLVERR, handled as INCR.

**Decode**
- A beat is in range when `ADDR_BASE` ≤ addr < `ADDR_BASE` + 4·`DEPTH_WORDS`.
- Out-of-range read beat: `rdata`=0, `rresp`=2'b11 (DECERR).
- Out-of-range write beat: memory is not written. B returns 2'b11 unless SLVERR already applies (SLVERR takes precedence).

**Concurrency**
- The read and write channels are fully independent; both may be active in the same cycle.
- `rdata` is registered when a beat is loaded. A write that commits in the same edge is not visible in that beat, but is visible in any later-loaded beat.

## Timing
- AR handshake at edge t → first `rvalid` at cycle t+1+`RD_LATENCY`.
- With `rready` held high, beats are back-to-back: one per cycle, len+1 cycles in total.
- AW handshake at edge t → `wready` from cycle t+1. With `wvalid` held high, W beats are accepted one per cycle.
- `bvalid` asserts in the cycle after the handshake of the W beat with `wlast`=1.
- `arready` is 0 from the AR handshake until the edge after the last R handshake.
- `awready` is 0 from the AW handshake until the B handshake.
- Minimum turnaround between back-to-back reads is one idle R_IDLE cycle.
- No output depends combinationally on any input.

## Test plan
- **Single write then read.**
  - Stimulus: AW 0x8000_0010 len0 size2 INCR, W 0xDEADBEEF strb 4'b1111; then AR of the same address.
  - Required: B OKAY with `bid` = awid. `rdata`=0xDEADBEEF, `rlast`=1, first `rvalid` exactly 3 cycles after AR (`RD_LATENCY`=2).
- **Byte strobe.**
  - Stimulus: write 0x11223344 strb 4'b0010 over a word holding 0xFFFFFFFF.
  - Required: read returns 0xFFFF33FF.
- **WRAP burst.**
  - Stimulus: words preloaded with value = address. AR 0x8000_0008 len3 size2 WRAP, `rready` toggling 1/0.
  - Required: `rdata` sequence 0x8000_0008, 0x8000_000C, 0x8000_0000, 0x8000_0004. `rlast` only on beat 4. Fields stable while `rready`=0.
- **Out of range.**
  - Stimulus: AR 0x7FFF_FFFC len1 INCR.
  - Required: beat 0 DECERR with `rdata`=0; beat 1 (0x8000_0000) OKAY.
- **Write error and wlast mismatch.**
  - Stimulus: AW len1 with `wlast` on beat 0; separately, AW with `awsize`=3.
  - Required: both B responses are SLVERR. The first returns after a single W beat.
- **Concurrency and reset.**
  - Stimulus: a 16-beat read overlapped with a 4-beat write to different addresses, then reset asserted mid-read at beat 5.
  - Required: both transactions complete with the correct data and ids. After reset, `rvalid`=0 immediately and `arready`=1 on the first cycle after reset deassertion.
